// File: rtl/prio_arbiter_rr.sv
// -----------------------------------------------------------------------------
// prio_arbiter_rr
//
// Registered request arbiter with selectable fixed (bit 0 highest) or
// round-robin priority, optional grant locking for multi-cycle transfers and
// an encoded grant index. The grant is registered, so gnt never depends
// combinationally on req.
//
// Parameters:
//   SIZE     number of requesters (>= 1, any value)
//   MODE     0 = fixed priority, 1 = round-robin
//   LOCK_EN  1 = granted requester keeps the grant while its req stays high
//   IDX_W    width of gnt_idx, derived from SIZE
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   req        request vector, one bit per requester
//   gnt        registered one-hot grant, zero when idle
//   gnt_valid  OR-reduction of gnt
//   gnt_idx    binary index of the set gnt bit, 0 when idle
// -----------------------------------------------------------------------------
module prio_arbiter_rr #(
    parameter  int SIZE    = 4,
    parameter  int MODE    = 1,
    parameter  int LOCK_EN = 1,
    localparam int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SIZE-1:0]  req,
    output logic [SIZE-1:0]  gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [SIZE-1:0]  gnt_q;
    logic [SIZE-1:0]  gnt_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    logic             hold;
    logic             found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] start_idx;
    int               k;

    // Mask of all requester positions whose index has bit b set; used to
    // build the one-hot to binary encoder as a plain OR per index bit.
    function automatic logic [SIZE-1:0] idx_mask(input int b);
        logic [SIZE-1:0] m;
        m = '0;
        for (int i = 0; i < SIZE; i++) begin
            m[i] = (((i >> b) & 1) == 1);
        end
        return m;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_enc
            assign gnt_idx[gi] = |(gnt_q & idx_mask(gi));
        end
    endgenerate

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;

    // gnt_q is one-hot, so "the granted requester still requests" is simply
    // a non-empty overlap between req and gnt_q.
    assign hold = (LOCK_EN != 0) && ((req & gnt_q) != '0);

    assign start_idx = (MODE == 1) ? ptr_q : '0;

    // Circular search from start_idx upward, wrapping modulo SIZE. The
    // wrap is done by subtraction so non-power-of-two SIZE never yields an
    // index beyond SIZE-1.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        k       = 0;
        for (int off = 0; off < SIZE; off++) begin
            k = int'(start_idx) + off;
            if (k >= SIZE) begin
                k = k - SIZE;
            end
            if (!found && req[k]) begin
                found   = 1'b1;
                win_idx = k[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        if (!hold) begin
            gnt_d = '0;
            if (found) begin
                gnt_d[win_idx] = 1'b1;
                if (MODE == 1) begin
                    // Winner drops to lowest priority for the next round.
                    if (win_idx == IDX_W'(SIZE - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// -----------------------------------------------------------------------------
// Bench for prio_arbiter_rr: six instances covering fixed/round-robin,
// lock on/off, SIZE 4, 5, 3 and 1. A behavioural model (grant as an integer
// index, pointer as an integer) predicts each instance; directed sequences
// with literal expectations come first, then randomized requests and resets.
// -----------------------------------------------------------------------------
module tb_prio_arbiter_rr;

    localparam int N = 6;
    localparam int SZ [N] = '{4, 4, 4, 5, 3, 1};
    localparam int MD [N] = '{0, 1, 1, 1, 0, 1};
    localparam int LK [N] = '{0, 0, 1, 0, 1, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_v [N];

    logic [3:0] g0, g1, g2;
    logic [4:0] g3;
    logic [2:0] g4;
    logic [0:0] g5;
    logic       v0, v1, v2, v3, v4, v5;
    logic [1:0] i0, i1, i2, i4;
    logic [2:0] i3;
    logic [0:0] i5;

    logic [7:0] gnt_v [N];
    logic [7:0] val_v [N];
    logic [7:0] idx_v [N];

    int mg [N];   // model grant index, -1 = idle
    int mp [N];   // model round-robin pointer

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_arbiter_rr #(.SIZE(4), .MODE(0), .LOCK_EN(0)) u_f (
        .clk(clk), .rst(rst), .req(req_v[0][3:0]), .gnt(g0), .gnt_valid(v0), .gnt_idx(i0));
    prio_arbiter_rr #(.SIZE(4), .MODE(1), .LOCK_EN(0)) u_r (
        .clk(clk), .rst(rst), .req(req_v[1][3:0]), .gnt(g1), .gnt_valid(v1), .gnt_idx(i1));
    prio_arbiter_rr #(.SIZE(4), .MODE(1), .LOCK_EN(1)) u_l (
        .clk(clk), .rst(rst), .req(req_v[2][3:0]), .gnt(g2), .gnt_valid(v2), .gnt_idx(i2));
    prio_arbiter_rr #(.SIZE(5), .MODE(1), .LOCK_EN(0)) u_5 (
        .clk(clk), .rst(rst), .req(req_v[3][4:0]), .gnt(g3), .gnt_valid(v3), .gnt_idx(i3));
    prio_arbiter_rr #(.SIZE(3), .MODE(0), .LOCK_EN(1)) u_fl (
        .clk(clk), .rst(rst), .req(req_v[4][2:0]), .gnt(g4), .gnt_valid(v4), .gnt_idx(i4));
    prio_arbiter_rr #(.SIZE(1), .MODE(1), .LOCK_EN(1)) u_1 (
        .clk(clk), .rst(rst), .req(req_v[5][0:0]), .gnt(g5), .gnt_valid(v5), .gnt_idx(i5));

    always_comb begin
        gnt_v[0] = {4'b0, g0}; val_v[0] = {7'b0, v0}; idx_v[0] = {6'b0, i0};
        gnt_v[1] = {4'b0, g1}; val_v[1] = {7'b0, v1}; idx_v[1] = {6'b0, i1};
        gnt_v[2] = {4'b0, g2}; val_v[2] = {7'b0, v2}; idx_v[2] = {6'b0, i2};
        gnt_v[3] = {3'b0, g3}; val_v[3] = {7'b0, v3}; idx_v[3] = {5'b0, i3};
        gnt_v[4] = {5'b0, g4}; val_v[4] = {7'b0, v4}; idx_v[4] = {6'b0, i4};
        gnt_v[5] = {7'b0, g5}; val_v[5] = {7'b0, v5}; idx_v[5] = {7'b0, i5};
    end

    // Reference rule: keep a locked grant while its request stays up,
    // otherwise take the first requester found walking upward from the
    // priority start with wrap-around; a round-robin winner hands priority
    // to the requester after it.
    function automatic void model_next(input int i, input logic [7:0] r,
                                       input int g, input int p,
                                       output int ng, output int np);
        int st;
        int k;
        ng = g;
        np = p;
        if (LK[i] != 0 && g >= 0 && r[g] == 1'b1) return;
        st = (MD[i] != 0) ? p : 0;
        ng = -1;
        for (int o = 0; o < SZ[i]; o++) begin
            k = (st + o) % SZ[i];
            if (ng < 0 && r[k] == 1'b1) ng = k;
        end
        if (ng >= 0 && MD[i] != 0) np = (ng + 1) % SZ[i];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int ng, np;
            if (rst) begin
                mg[i] <= -1;
                mp[i] <= 0;
            end else begin
                model_next(i, req_v[i], mg[i], mp[i], ng, np);
                mg[i] <= ng;
                mp[i] <= np;
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h expected %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [7:0] eg, ei, ev;
        for (int i = 0; i < N; i++) begin
            eg = (mg[i] >= 0) ? (8'd1 << mg[i]) : 8'd0;
            ei = (mg[i] >= 0) ? 8'(mg[i]) : 8'd0;
            ev = (mg[i] >= 0) ? 8'd1 : 8'd0;
            chk("model_gnt", i, gnt_v[i], eg);
            chk("model_valid", i, val_v[i], ev);
            chk("model_idx", i, idx_v[i], ei);
        end
    endtask

    // Advance to the next falling edge and check every instance against the model.
    task automatic step();
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        logic [7:0] seq2_g [5];
        logic [7:0] seq2_i [5];
        seq2_g = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01};
        seq2_i = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};

        rst = 1'b1;
        for (int i = 0; i < N; i++) req_v[i] = 8'h00;
        step();
        step();
        chk("reset_gnt", 2, gnt_v[2], 8'h00);
        chk("reset_valid", 2, val_v[2], 8'h00);
        chk("reset_idx", 2, idx_v[2], 8'h00);
        rst = 1'b0;
        step();

        // Fixed priority, no lock: lowest set bit wins every cycle.
        req_v[0] = 8'h0A;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("fixed_gnt", 0, gnt_v[0], 8'h02);
            chk("fixed_idx", 0, idx_v[0], 8'h01);
        end
        req_v[0] = 8'h00;
        step();
        chk("fixed_idle", 0, gnt_v[0], 8'h00);
        chk("fixed_idle_valid", 0, val_v[0], 8'h00);

        // Round-robin rotation over all four requesters.
        req_v[1] = 8'h0F;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("rr_all_gnt", 1, gnt_v[1], seq2_g[c]);
            chk("rr_all_idx", 1, idx_v[1], seq2_i[c]);
        end
        // Pointer is 1 now: 1001 gives 1000 then 0001; then 0110 gives 0010.
        req_v[1] = 8'h09;
        step();
        chk("rr_pair_gnt", 1, gnt_v[1], 8'h08);
        step();
        chk("rr_pair_gnt", 1, gnt_v[1], 8'h01);
        req_v[1] = 8'h06;
        step();
        chk("rr_switch_gnt", 1, gnt_v[1], 8'h02);

        // Lock: bit 0 keeps the grant four cycles, then bit 1 takes over.
        req_v[2] = 8'h03;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("lock_hold_gnt", 2, gnt_v[2], 8'h01);
        end
        req_v[2] = 8'h02;
        step();
        chk("lock_pass_gnt", 2, gnt_v[2], 8'h02);
        chk("lock_pass_idx", 2, idx_v[2], 8'h01);
        req_v[2] = 8'h05;
        step();
        chk("lock_next_gnt", 2, gnt_v[2], 8'h04);
        req_v[2] = 8'h0F;
        step();
        chk("lock_keep_gnt", 2, gnt_v[2], 8'h04);

        // Reset in the middle of a lock drops the grant and the pointer.
        rst = 1'b1;
        step();
        chk("rst_lock_gnt", 2, gnt_v[2], 8'h00);
        chk("rst_lock_valid", 2, val_v[2], 8'h00);
        rst = 1'b0;
        step();
        chk("post_rst_gnt", 2, gnt_v[2], 8'h01);

        // SIZE=5 wrap from index 4 back to 0.
        req_v[3] = 8'h11;
        step();
        chk("s5_gnt", 3, gnt_v[3], 8'h01);
        chk("s5_idx", 3, idx_v[3], 8'h00);
        step();
        chk("s5_gnt", 3, gnt_v[3], 8'h10);
        chk("s5_idx", 3, idx_v[3], 8'h04);
        step();
        chk("s5_gnt", 3, gnt_v[3], 8'h01);
        chk("s5_idx", 3, idx_v[3], 8'h00);

        // SIZE=1 follows req one cycle later.
        req_v[5] = 8'h01;
        step();
        chk("s1_gnt", 5, gnt_v[5], 8'h01);
        req_v[5] = 8'h00;
        step();
        chk("s1_gnt", 5, gnt_v[5], 8'h00);

        // Randomized phase: requests often held to exercise locking, sparse
        // patterns mixed in, occasional reset.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    logic [7:0] r;
                    r = 8'($urandom);
                    if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
                    req_v[i] = r & 8'((1 << SZ[i]) - 1);
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
